// File: rtl/weight_load_ctrl_pkg.sv
// Shared definitions for the layer weight loader: FSM states and the
// bit positions of the layer/neuron fields inside a header word.
package weight_load_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      LOAD  = 2'd2,
      SKIP  = 2'd3
   } state_e;

   localparam int LAYER_MSB   = 15;
   localparam int LAYER_LSB   = 8;
   localparam int NEURON_MSB  = 7;
   localparam int NEURON_LSB  = 0;
   localparam int HDR_FIELD_W = LAYER_MSB - LAYER_LSB + 1;

endpackage

// File: rtl/weight_load_ctrl.sv
// Streams one layer's weights from a valid/ready config channel into the
// per-neuron weight memories, pausing whenever the layer is running inference.
module weight_load_ctrl
   import weight_load_ctrl_pkg::*;
#(
   parameter int LAYER_NO    = 1,
   parameter int NUM_NEURONS = 30,
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 16
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_valid,
   input  logic [DATA_WIDTH-1:0]  cfg_data,
   output logic                   cfg_ready,
   input  logic                   infer_busy,
   output logic [NUM_NEURONS-1:0] wen_vec,
   output logic [ADDR_WIDTH-1:0]  wadd,
   output logic [DATA_WIDTH-1:0]  win,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam logic [DATA_WIDTH:0]    MaxWords   = (DATA_WIDTH+1)'(1) << ADDR_WIDTH;
   localparam logic [NUM_NEURONS-1:0] NeuronBit0 = NUM_NEURONS'(1);
   localparam logic [ADDR_WIDTH:0]    IdxOne     = (ADDR_WIDTH+1)'(1);
   localparam logic [DATA_WIDTH-1:0]  RemainOne  = DATA_WIDTH'(1);

   state_e                 state_q;
   logic                   readyEn_q;
   logic [HDR_FIELD_W-1:0] layerId_q;
   logic [HDR_FIELD_W-1:0] neuronId_q;
   logic [ADDR_WIDTH:0]    idx_q;
   logic [DATA_WIDTH-1:0]  remain_q;
   logic [NUM_NEURONS-1:0] wenVec_q;
   logic [ADDR_WIDTH-1:0]  wadd_q;
   logic [DATA_WIDTH-1:0]  win_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   err_q;

   logic                   accept;
   logic                   lastWord;
   logic                   badTarget;
   logic                   tooLong;
   logic [HDR_FIELD_W-1:0] hdrLayer;
   logic [HDR_FIELD_W-1:0] hdrNeuron;
   logic [NUM_NEURONS-1:0] neuronOneHot;

   // readyEn_q keeps cfg_ready low while reset is held; inside LOAD the
   // handshake is gated directly by infer_busy so reads and writes never overlap.
   assign cfg_ready = readyEn_q && ((state_q != LOAD) || !infer_busy);
   assign accept    = cfg_valid && cfg_ready;

   assign hdrLayer     = cfg_data[LAYER_MSB:LAYER_LSB];
   assign hdrNeuron    = cfg_data[NEURON_MSB:NEURON_LSB];
   assign badTarget    = (layerId_q != HDR_FIELD_W'(LAYER_NO)) ||
                         (32'(neuronId_q) >= 32'(NUM_NEURONS));
   assign tooLong      = ({1'b0, cfg_data} > MaxWords);
   assign lastWord     = (remain_q == RemainOne);
   assign neuronOneHot = NeuronBit0 << neuronId_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         readyEn_q  <= 1'b0;
         layerId_q  <= '0;
         neuronId_q <= '0;
         idx_q      <= '0;
         remain_q   <= '0;
         wenVec_q   <= '0;
         wadd_q     <= '0;
         win_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         readyEn_q <= 1'b1;
         wenVec_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;

         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  layerId_q  <= hdrLayer;
                  neuronId_q <= hdrNeuron;
                  busy_q     <= 1'b1;
                  state_q    <= COUNT;
               end
            end

            // An empty load finishes immediately; a rejected one still drains its words.
            COUNT: begin
               if (accept) begin
                  remain_q <= cfg_data;
                  idx_q    <= '0;
                  if (cfg_data == '0) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else if (badTarget || tooLong) begin
                     err_q   <= 1'b1;
                     state_q <= SKIP;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (accept) begin
                  wenVec_q <= neuronOneHot;
                  wadd_q   <= idx_q[ADDR_WIDTH-1:0];
                  win_q    <= cfg_data;
                  idx_q    <= idx_q + IdxOne;
                  remain_q <= remain_q - RemainOne;
                  if (lastWord) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end

            SKIP: begin
               if (accept) begin
                  remain_q <= remain_q - RemainOne;
                  if (lastWord) begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign wen_vec = wenVec_q;
   assign wadd    = wadd_q;
   assign win     = win_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: directed table, hand-written
// pause/reset sequences and randomized loads against a transaction-level model.
module tb_weight_load_ctrl;

   localparam int LayerNo    = 1;
   localparam int NumNeurons = 30;
   localparam int AddrWidth  = 10;
   localparam int DataWidth  = 16;

   localparam int KindWrite = 0;
   localparam int KindDone  = 1;
   localparam int KindErr   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic                  cfg_valid = 1'b0;
   logic [DataWidth-1:0]  cfg_data = '0;
   logic                  cfg_ready;
   logic                  infer_busy;
   logic [NumNeurons-1:0] wen_vec;
   logic [AddrWidth-1:0]  wadd;
   logic [DataWidth-1:0]  win;
   logic                  busy;
   logic                  done;
   logic                  err;

   logic randomInfer = 1'b0;
   logic rndBusy     = 1'b0;
   logic forceBusy   = 1'b0;

   int checks = 0;
   int errors = 0;
   int writesSeen = 0;
   int doneSeen = 0;
   int errSeen = 0;
   int lastWaddSeen = -1;

   typedef struct {
      int             kind;
      int             neuron;
      int             addr;
      logic [15:0]    data;
      bit             last;
   } exp_t;

   typedef struct {
      logic [15:0] hdr;
      logic [15:0] cnt;
      int          gapPct;
      int          expWrites;
      int          expDone;
      int          expErr;
      int          expLastAddr;
   } vec_t;

   exp_t expQ[$];
   exp_t monEvt;
   vec_t vecs[8];

   assign infer_busy = randomInfer ? rndBusy : forceBusy;

   always #5 clk = ~clk;

   weight_load_ctrl #(
      .LAYER_NO   (LayerNo),
      .NUM_NEURONS(NumNeurons),
      .ADDR_WIDTH (AddrWidth),
      .DATA_WIDTH (DataWidth)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .infer_busy(infer_busy),
      .wen_vec   (wen_vec),
      .wadd      (wadd),
      .win       (win),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Transaction-level model: what a whole header/count/words burst must produce.
   task automatic buildExpectation(input logic [15:0] hdr, input logic [15:0] cnt, input logic [15:0] base);
      int layer  = int'(hdr[15:8]);
      int neuron = int'(hdr[7:0]);
      int n      = int'(cnt);
      if (n == 0)
         expQ.push_back('{KindDone, 0, 0, 16'h0, 1'b1});
      else if (layer != LayerNo || neuron >= NumNeurons || n > (1 << AddrWidth))
         expQ.push_back('{KindErr, 0, 0, 16'h0, 1'b0});
      else
         for (int i = 0; i < n; i++)
            expQ.push_back('{KindWrite, neuron, i, base + 16'(i), (i == n - 1)});
   endtask

   task automatic sendWord(input logic [15:0] w, input int gapPct);
      bit accepted = 1'b0;
      while (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
         cfg_valid = 1'b0;
         @(negedge clk);
      end
      cfg_valid = 1'b1;
      cfg_data  = w;
      for (int c = 0; c < 200 && !accepted; c++) begin
         #4;
         accepted = cfg_ready;
         @(negedge clk);
      end
      cfg_valid = 1'b0;
      checkOutput("wordAccepted", 64'(accepted), 64'd1);
   endtask

   task automatic applyStimulus(input logic [15:0] hdr, input logic [15:0] cnt, input logic [15:0] base, input int gapPct);
      buildExpectation(hdr, cnt, base);
      sendWord(hdr, gapPct);
      sendWord(cnt, gapPct);
      for (int i = 0; i < int'(cnt); i++)
         sendWord(base + 16'(i), gapPct);
   endtask

   task automatic waitDrain();
      int c = 0;
      while (expQ.size() != 0 && c < 50) begin
         @(negedge clk);
         c++;
      end
      repeat (2) @(negedge clk);
      checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
      checkOutput("busyIdle", 64'(busy), 64'd0);
      expQ.delete();
   endtask

   always @(negedge clk) begin
      if (randomInfer)
         rndBusy = ($urandom_range(3) == 0);
   end

   // Every write/done/err event must match the next item the model expects.
   always @(negedge clk) begin
      if (rst_n) begin
         if (wen_vec != '0) begin
            writesSeen++;
            lastWaddSeen = int'(wadd);
         end
         if (done) doneSeen++;
         if (err) errSeen++;
         if (wen_vec != '0 || done || err) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedEvent", 64'({wen_vec, done, err}), 64'd0);
            end else begin
               monEvt = expQ.pop_front();
               case (monEvt.kind)
                  KindWrite: begin
                     checkOutput("wenOneHot", 64'(wen_vec), 64'd1 << monEvt.neuron);
                     checkOutput("wadd", 64'(wadd), 64'(monEvt.addr));
                     checkOutput("win", 64'(win), 64'(monEvt.data));
                     checkOutput("doneWithLastWrite", 64'(done), 64'(monEvt.last));
                     checkOutput("busyDuringLoad", 64'(busy), 64'(!monEvt.last));
                     checkOutput("noErrOnWrite", 64'(err), 64'd0);
                  end
                  KindDone: begin
                     checkOutput("emptyLoadDone", 64'(done), 64'd1);
                     checkOutput("emptyLoadNoWen", 64'(wen_vec), 64'd0);
                     checkOutput("emptyLoadBusy", 64'(busy), 64'd0);
                  end
                  default: begin
                     checkOutput("rejectErr", 64'(err), 64'd1);
                     checkOutput("rejectNoWen", 64'(wen_vec), 64'd0);
                     checkOutput("rejectNoDone", 64'(done), 64'd0);
                     checkOutput("rejectBusy", 64'(busy), 64'd1);
                  end
               endcase
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{16'h0103, 16'd3,    0,  3,    1, 0, 2};
      vecs[1] = '{16'h0203, 16'd2,    0,  0,    0, 1, -1};
      vecs[2] = '{16'h011E, 16'd2,    0,  0,    0, 1, -1};
      vecs[3] = '{16'h0105, 16'd1025, 0,  0,    0, 1, -1};
      vecs[4] = '{16'h0109, 16'd1024, 0,  1024, 1, 0, 1023};
      vecs[5] = '{16'h0104, 16'd0,    0,  0,    1, 0, -1};
      vecs[6] = '{16'h011D, 16'd1,    0,  1,    1, 0, 0};
      vecs[7] = '{16'h0103, 16'd3,    40, 3,    1, 0, 2};

      #1 rst_n = 1'b0;
      #2;
      checkOutput("rstCfgReady", 64'(cfg_ready), 64'd0);
      checkOutput("rstWen", 64'(wen_vec), 64'd0);
      checkOutput("rstWadd", 64'(wadd), 64'd0);
      checkOutput("rstWin", 64'(win), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstErr", 64'(err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed table");
      for (int v = 0; v < 8; v++) begin
         writesSeen   = 0;
         doneSeen     = 0;
         errSeen      = 0;
         lastWaddSeen = -1;
         applyStimulus(vecs[v].hdr, vecs[v].cnt, 16'hA000 + 16'(v * 16'h100), vecs[v].gapPct);
         waitDrain();
         checkOutput($sformatf("vec%0d_writes", v), 64'(writesSeen), 64'(vecs[v].expWrites));
         checkOutput($sformatf("vec%0d_done", v), 64'(doneSeen), 64'(vecs[v].expDone));
         checkOutput($sformatf("vec%0d_err", v), 64'(errSeen), 64'(vecs[v].expErr));
         checkOutput($sformatf("vec%0d_lastWadd", v), 64'(lastWaddSeen), 64'(vecs[v].expLastAddr));
      end

      $display("[TB] inference pause mid-load");
      writesSeen = 0;
      buildExpectation(16'h0103, 16'd3, 16'hB000);
      sendWord(16'h0103, 0);
      sendWord(16'd3, 0);
      sendWord(16'hB000, 0);
      forceBusy = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 16'hB001;
      for (int c = 0; c < 4; c++) begin
         #4;
         checkOutput("readyLowWhileInfer", 64'(cfg_ready), 64'd0);
         checkOutput("busyDuringPause", 64'(busy), 64'd1);
         if (c > 0) checkOutput("noWenWhileInfer", 64'(wen_vec), 64'd0);
         @(negedge clk);
      end
      forceBusy = 1'b0;
      sendWord(16'hB001, 0);
      sendWord(16'hB002, 0);
      waitDrain();
      checkOutput("pauseWrites", 64'(writesSeen), 64'd3);

      $display("[TB] async reset mid-load");
      buildExpectation(16'h0107, 16'd5, 16'hC000);
      sendWord(16'h0107, 0);
      sendWord(16'd5, 0);
      sendWord(16'hC000, 0);
      sendWord(16'hC001, 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstCfgReady", 64'(cfg_ready), 64'd0);
      checkOutput("midRstWen", 64'(wen_vec), 64'd0);
      checkOutput("midRstWadd", 64'(wadd), 64'd0);
      checkOutput("midRstWin", 64'(win), 64'd0);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      checkOutput("midRstDone", 64'(done), 64'd0);
      checkOutput("midRstErr", 64'(err), 64'd0);
      expQ.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      writesSeen = 0;
      doneSeen   = 0;
      applyStimulus(16'h0107, 16'd2, 16'hD000, 0);
      waitDrain();
      checkOutput("postRstWrites", 64'(writesSeen), 64'd2);
      checkOutput("postRstDone", 64'(doneSeen), 64'd1);

      $display("[TB] randomized loads");
      randomInfer = 1'b1;
      for (int t = 0; t < 40; t++) begin
         logic [7:0]  layer;
         logic [7:0]  neuron;
         logic [15:0] cnt;
         layer  = ($urandom_range(9) == 0) ? 8'd2 : 8'd1;
         neuron = 8'($urandom_range(33));
         cnt    = 16'($urandom_range(6));
         applyStimulus({layer, neuron}, cnt, 16'($urandom), 30);
         waitDrain();
      end
      randomInfer = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
